cc_fill_sequencer: RTL and testbench

- Cache-line fill controller for the cache controller (CC), sitting between the miss request FIFO and the memory-side AXI read channel.
- Pops one miss address at a time and issues an 8-beat x 64-bit AXI read for the 64-byte line.
- Writes the returned beats into the data array, then writes the tag array entry.
- Returns the requested 32-bit word to the INCT-side response path.
- Handles one miss at a time; `busy_o` and `fill_index_o` support hazard checks.

---
 rtl/cc_fill_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cc_fill_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_fill_sequencer.sv
// Purpose : cache-line fill controller; pops one miss, issues an 8x64b AXI INCR read,
//           writes the beats into the data array, then the tag entry, then returns the word.
// Latency : pop T0, AR T1, beats T2..T9, tag write T10, response T11 (zero wait states).
// Backpr. : AR held until arready, R accepted only while reading, response held until rsp_ready.
//
// Ports:
//   miss_req_*  show-ahead miss FIFO (empty / rdata / rden pop strobe)
//   mem_ar*     AXI read-address channel (ID/len/size/burst are constants)
//   mem_r*      AXI read-data channel
//   data_*      data array write port, address {index, beat}
//   tag_*       tag array write port, data {valid, tag}
//   rsp_*       requested-word response with error flag
//   busy_o / fill_index_o  hazard-check view of the line being filled
module cc_fill_sequencer #(
  parameter logic [3:0] MEM_ARID = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_req_empty_i,
  input  logic [31:0] miss_req_rdata_i,
  output logic        miss_req_rden_o,
  output logic [3:0]  mem_arid_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  input  logic [63:0] mem_rdata_i,
  input  logic [1:0]  mem_rresp_i,
  input  logic        mem_rlast_i,
  input  logic        mem_rvalid_i,
  output logic        mem_rready_o,
  output logic        data_wren_o,
  output logic [10:0] data_waddr_o,
  output logic [63:0] data_wdata_o,
  output logic        tag_wren_o,
  output logic [7:0]  tag_waddr_o,
  output logic [18:0] tag_wdata_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  input  logic        rsp_ready_i,
  output logic        busy_o,
  output logic [7:0]  fill_index_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_RD   = 3'd2,
    S_TAG  = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;     // beat counter, saturates at 8
  logic        err_q, err_d;
  logic [31:0] word_q, word_d;   // captured requested word, 0 until its beat arrives

  logic [17:0] line_tag;
  logic [7:0]  line_index;
  logic [2:0]  req_beat;
  logic        word_sel;
  logic        pop;
  logic        r_hs;
  logic        beat_in_range;
  logic        unused_addr_bits;

  assign line_tag   = addr_q[31:14];
  assign line_index = addr_q[13:6];
  assign req_beat   = addr_q[5:3];
  assign word_sel   = addr_q[2];

  // Byte-within-word bits have no meaning for a word-granular response.
  assign unused_addr_bits = ^addr_q[1:0];

  // Pop is suppressed while reset is asserted so no miss is lost to a reset pulse.
  assign pop           = (state_q == S_IDLE) && !miss_req_empty_i && rst_n;
  assign r_hs          = (state_q == S_RD) && mem_rvalid_i;
  assign beat_in_range = !cnt_q[3];

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pop)                      state_d = S_AR;
      S_AR:   if (mem_arready_i)            state_d = S_RD;
      S_RD:   if (r_hs && mem_rlast_i)      state_d = S_TAG;
      S_TAG:                                state_d = S_RSP;
      S_RSP:  if (rsp_ready_i)              state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      word_q <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      word_q <= word_d;
    end
  end

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    word_d = word_q;
    if (pop) begin
      addr_d = miss_req_rdata_i;
      cnt_d  = '0;
      err_d  = 1'b0;
      word_d = '0;
    end
    if (r_hs) begin
      if (beat_in_range) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q[2:0] == req_beat) begin
          word_d = word_sel ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
        end
      end else begin
        // Beats past the eighth are drained without a write and poison the line.
        err_d = 1'b1;
      end
      if (mem_rresp_i != 2'b00) begin
        err_d = 1'b1;
      end
      // A burst that ends on anything but the eighth beat is incomplete or overlong.
      if (mem_rlast_i && (cnt_q != 4'd7)) begin
        err_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  // Data-carrying outputs are zeroed when their strobe is low so that an
  // asynchronous reset drives every non-constant output to 0 immediately.
  always_comb begin
    miss_req_rden_o = pop;
    mem_arid_o      = MEM_ARID;
    mem_arlen_o     = 4'd7;
    mem_arsize_o    = 3'd3;
    mem_arburst_o   = 2'b01;
    mem_arvalid_o   = (state_q == S_AR);
    mem_araddr_o    = mem_arvalid_o ? {addr_q[31:6], 6'b0} : 32'd0;
    mem_rready_o    = (state_q == S_RD);
    data_wren_o     = r_hs && beat_in_range;
    data_waddr_o    = data_wren_o ? {line_index, cnt_q[2:0]} : 11'd0;
    data_wdata_o    = data_wren_o ? mem_rdata_i : 64'd0;
    tag_wren_o      = (state_q == S_TAG);
    tag_waddr_o     = tag_wren_o ? line_index : 8'd0;
    tag_wdata_o     = tag_wren_o ? {!err_q, line_tag} : 19'd0;
    rsp_valid_o     = (state_q == S_RSP);
    rsp_data_o      = rsp_valid_o ? word_q : 32'd0;
    rsp_err_o       = rsp_valid_o && err_q;
    busy_o          = (state_q != S_IDLE);
    fill_index_o    = busy_o ? line_index : 8'd0;
  end

endmodule

// File: tb/tb_cc_fill_sequencer.sv
// Purpose : self-checking bench for cc_fill_sequencer; a table of directed fills plus
//           random fills checked against a line-level model, and hand sequences for
//           back-to-back misses and reset in the middle of a burst.
module tb_cc_fill_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_req_empty_i;
  logic [31:0] miss_req_rdata_i;
  logic        miss_req_rden_o;
  logic [3:0]  mem_arid_o;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic [63:0] mem_rdata_i;
  logic [1:0]  mem_rresp_i;
  logic        mem_rlast_i;
  logic        mem_rvalid_i;
  logic        mem_rready_o;
  logic        data_wren_o;
  logic [10:0] data_waddr_o;
  logic [63:0] data_wdata_o;
  logic        tag_wren_o;
  logic [7:0]  tag_waddr_o;
  logic [18:0] tag_wdata_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        rsp_ready_i;
  logic        busy_o;
  logic [7:0]  fill_index_o;

  cc_fill_sequencer #(.MEM_ARID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req_empty_i(miss_req_empty_i), .miss_req_rdata_i(miss_req_rdata_i),
    .miss_req_rden_o(miss_req_rden_o),
    .mem_arid_o(mem_arid_o), .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
    .mem_arsize_o(mem_arsize_o), .mem_arburst_o(mem_arburst_o),
    .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i),
    .mem_rdata_i(mem_rdata_i), .mem_rresp_i(mem_rresp_i), .mem_rlast_i(mem_rlast_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o),
    .data_wren_o(data_wren_o), .data_waddr_o(data_waddr_o), .data_wdata_o(data_wdata_o),
    .tag_wren_o(tag_wren_o), .tag_waddr_o(tag_waddr_o), .tag_wdata_o(tag_wdata_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .rsp_ready_i(rsp_ready_i), .busy_o(busy_o), .fill_index_o(fill_index_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] fifo[$];
  logic [63:0] beats[16];

  typedef struct {
    logic [31:0] addr;
    int          ar_stall;
    int          r_gap;
    int          rsp_stall;
    int          nbeats;
    int          err_beat;   // 15 = no error response
    int          exp_wr;
    logic        exp_tv;
    logic        exp_err;
    logic [31:0] exp_rsp;
    bit          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [181:0] out_vec();
    return {miss_req_rden_o, mem_arvalid_o, mem_araddr_o, mem_rready_o,
            data_wren_o, data_waddr_o, data_wdata_o, tag_wren_o, tag_waddr_o,
            tag_wdata_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o, fill_index_o};
  endfunction

  task automatic chk_quiet(input string name);
    chk(name, {63'd0, (out_vec() != '0)}, 64'd0);
    chk({name, "_const"}, {mem_arid_o, mem_arlen_o, mem_arsize_o, mem_arburst_o},
        {4'd0, 4'd7, 3'd3, 2'b01});
  endtask

  function automatic void set_pattern();
    for (int k = 0; k < 16; k++) beats[k] = {32'hB000_0000 | k, 32'hA000_0000 | k};
  endfunction

  // Line-level expectation: what a fill of nbeats beats with an optional SLVERR yields.
  task automatic model(input logic [31:0] addr, input int nbeats, input int err_beat,
                       output int wr, output logic tv, output logic err,
                       output logic [31:0] rsp);
    int rb;
    rb  = int'(addr[5:3]);
    wr  = (nbeats < 8) ? nbeats : 8;
    err = (nbeats != 8) || (err_beat < nbeats);
    tv  = !err;
    if (rb < nbeats) rsp = addr[2] ? beats[rb][63:32] : beats[rb][31:0];
    else             rsp = 32'd0;
  endtask

  // Plays memory, FIFO consumer and response sink for one fill, checking every cycle.
  task automatic run_fill(input logic [31:0] addr, input int ar_stall, input int r_gap,
                          input int rsp_stall, input int nbeats, input int err_beat,
                          input int abort_beats, input int exp_wr, input logic exp_tv,
                          input logic exp_err, input logic [31:0] exp_rsp,
                          input bit lat, output int pop_t);
    int ar_wait = 0, rsp_wait = 0, bi = 0, nwr = 0, ntag = 0, npop = 0, nar = 0;
    int budget = 0, t_tag = -1, t_rsp = -1;
    bit ar_done = 0, popped = 0, done = 0, rv;
    logic [7:0] idx;
    idx   = addr[13:6];
    pop_t = -1;
    while (!done && budget < 400) begin
      budget++;
      mem_arready_i = (ar_wait >= ar_stall);
      rv = ar_done && (bi < nbeats) && (r_gap == 0 || (budget % 2) == 0);
      mem_rvalid_i = rv;
      mem_rdata_i  = rv ? beats[bi] : 64'd0;
      mem_rresp_i  = (rv && bi == err_beat) ? 2'b10 : 2'b00;
      mem_rlast_i  = rv && (bi == nbeats - 1);
      miss_req_empty_i = (fifo.size() == 0);
      miss_req_rdata_i = (fifo.size() == 0) ? 32'd0 : fifo[0];
      rsp_ready_i = (rsp_wait >= rsp_stall);
      #1;
      if (miss_req_rden_o) begin
        npop++;
        chk("pop_busy", {63'd0, busy_o}, 64'd0);
        if (fifo.size() == 0) chk("pop_when_empty", 64'd1, 64'd0);
        else begin
          chk("pop_addr", {32'd0, fifo[0]}, {32'd0, addr});
          void'(fifo.pop_front());
        end
        popped = 1;
        pop_t  = cyc;
      end else if (popped) begin
        chk("busy", {63'd0, busy_o}, 64'd1);
        chk("fill_index", {56'd0, fill_index_o}, {56'd0, idx});
      end
      if (mem_arvalid_o) begin
        nar++;
        chk("araddr", {32'd0, mem_araddr_o}, {32'd0, addr[31:6], 6'b0});
        chk("ar_const", {mem_arid_o, mem_arlen_o, mem_arsize_o, mem_arburst_o},
            {4'd0, 4'd7, 3'd3, 2'b01});
        if (mem_arready_i) ar_done = 1;
        else ar_wait++;
      end
      if (data_wren_o) begin
        if (nwr < 16) begin
          chk("data_waddr", {53'd0, data_waddr_o}, {53'd0, idx, 3'(nwr)});
          chk("data_wdata", data_wdata_o, beats[nwr]);
        end
        nwr++;
      end
      if (rv && mem_rready_o) bi++;
      if (tag_wren_o) begin
        ntag++;
        t_tag = cyc;
        chk("tag_waddr", {56'd0, tag_waddr_o}, {56'd0, idx});
        chk("tag_wdata", {45'd0, tag_wdata_o}, {45'd0, exp_tv, addr[31:14]});
      end
      if (rsp_valid_o) begin
        if (t_rsp < 0) t_rsp = cyc;
        chk("rsp_data", {32'd0, rsp_data_o}, {32'd0, exp_rsp});
        chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, exp_err});
        if (rsp_ready_i) done = 1;
        else rsp_wait++;
      end
      @(negedge clk);
      if (abort_beats > 0 && bi >= abort_beats && !done) begin
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_quiet("reset_midfill_outputs");
        chk("abort_writes", 64'(nwr), 64'(abort_beats));
        @(negedge clk);
        chk("reset_no_tag", {63'd0, tag_wren_o}, 64'd0);
        chk("reset_no_pop", {63'd0, miss_req_rden_o}, 64'd0);
        rst_n = 1'b1;
        return;
      end
    end
    chk("fill_done_in_budget", {63'd0, done}, 64'd1);
    chk("pop_count", 64'(npop), 64'd1);
    chk("write_count", 64'(nwr), 64'(exp_wr));
    chk("tag_count", 64'(ntag), 64'd1);
    chk("arvalid_cycles", 64'(nar), 64'(ar_stall + 1));
    if (lat) begin
      chk("lat_tag", 64'(t_tag - pop_t), 64'd10);
      chk("lat_rsp", 64'(t_rsp - pop_t), 64'd11);
    end
  endtask

  initial begin
    int          pt[3];
    int          dummy;
    int          wr, nb, eb;
    logic        tv, er;
    logic [31:0] rs, a;

    //            addr          ars gap rss nb eb  wr tv er rsp            lat
    vecs[0] = '{32'h0001_2348, 0, 0, 0,  8, 15, 8, 1, 0, 32'hA000_0001, 1};
    vecs[1] = '{32'h0001_234C, 5, 1, 3,  8, 15, 8, 1, 0, 32'hB000_0001, 0};
    vecs[2] = '{32'h00AB_C0F0, 0, 0, 0,  8,  3, 8, 0, 1, 32'hA000_0006, 0};
    vecs[3] = '{32'h1234_5668, 0, 0, 0,  4, 15, 4, 0, 1, 32'h0000_0000, 0};
    vecs[4] = '{32'h1234_5654, 0, 1, 1,  4, 15, 4, 0, 1, 32'hB000_0002, 0};
    vecs[5] = '{32'hFFFF_FFFC, 1, 0, 0, 10, 15, 8, 0, 1, 32'hB000_0007, 0};
    vecs[6] = '{32'h8000_0000, 0, 0, 2,  1, 15, 1, 0, 1, 32'hA000_0000, 0};

    rst_n = 1'b0;
    miss_req_empty_i = 1'b1;
    miss_req_rdata_i = '0;
    mem_arready_i = 1'b0;
    mem_rdata_i = '0;
    mem_rresp_i = '0;
    mem_rlast_i = 1'b0;
    mem_rvalid_i = 1'b0;
    rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_quiet("idle_empty_outputs");
    @(negedge clk);

    // Directed table
    set_pattern();
    for (int i = 0; i < 7; i++) begin
      fifo.push_back(vecs[i].addr);
      run_fill(vecs[i].addr, vecs[i].ar_stall, vecs[i].r_gap, vecs[i].rsp_stall,
               vecs[i].nbeats, vecs[i].err_beat, 0, vecs[i].exp_wr, vecs[i].exp_tv,
               vecs[i].exp_err, vecs[i].exp_rsp, vecs[i].lat, dummy);
    end

    // Back-to-back: three queued misses, zero wait states
    fifo.push_back(32'h0000_0040);
    fifo.push_back(32'h0000_3FC4);
    fifo.push_back(32'hDEAD_BEE8);
    run_fill(32'h0000_0040, 0, 0, 0, 8, 15, 0, 8, 1, 0, 32'hA000_0000, 1, pt[0]);
    run_fill(32'h0000_3FC4, 0, 0, 0, 8, 15, 0, 8, 1, 0, 32'hB000_0000, 1, pt[1]);
    run_fill(32'hDEAD_BEE8, 0, 0, 0, 8, 15, 0, 8, 1, 0, 32'hA000_0005, 1, pt[2]);
    chk("b2b_spacing_1", 64'(pt[1] - pt[0]), 64'd12);
    chk("b2b_spacing_2", 64'(pt[2] - pt[1]), 64'd12);

    // Reset after the fourth beat, with the next miss already waiting
    fifo.push_back(32'h0F0F_0F18);
    fifo.push_back(32'h0555_5524);
    run_fill(32'h0F0F_0F18, 0, 0, 0, 8, 15, 4, 8, 1, 0, 32'h0, 0, dummy);
    chk("after_reset_fifo_kept", 64'(fifo.size()), 64'd1);
    run_fill(32'h0555_5524, 0, 0, 0, 8, 15, 0, 8, 1, 0, 32'hB000_0004, 1, dummy);

    // Random fills against the line-level model
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 16; k++) beats[k] = {$urandom, $urandom};
      a  = $urandom;
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 8;
      eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nb - 1)) : 15;
      model(a, nb, eb, wr, tv, er, rs);
      fifo.push_back(a);
      run_fill(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), nb, eb, 0, wr, tv, er, rs, 0, dummy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
